reorder_buffer_tagged: RTL and testbench

//  Parametrised read-channel reorder buffer between an in-order AXI-style slave and an out-of-order master.

---
 rtl/rob_pkg.sv | 19 +
 rtl/rob_slot_tracker.sv | 53 +++++
 rtl/reorder_buffer_tagged.sv | 118 +++++++++++
 tb/tb_reorder_buffer_tagged.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared widths and helper types for the tagged read reorder buffer.
// Optional protocol checking is enabled by defining ROB_CHECK_EN.
package rob_pkg;

  localparam int unsigned ROB_DATA_WIDTH = 8;
  localparam int unsigned ROB_ID_WIDTH   = 4;
  localparam int unsigned ROB_DEPTH      = 16;
  localparam int unsigned ROB_TAG_WIDTH  = $clog2(ROB_DEPTH);

  // Default-width helpers; parametrised instances size their own storage.
  typedef logic [ROB_TAG_WIDTH-1:0] tag_t;
  typedef logic [ROB_TAG_WIDTH:0]   ptr_t;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0]   id;
    logic [ROB_DATA_WIDTH-1:0] data;
  } rob_slot_t;

endpackage

// File: rtl/rob_slot_tracker.sv
// Per-slot completion bits for the reorder buffer: set by response tag, cleared at the head.
// With ROB_CHECK_EN defined, responses to non-outstanding or already-done slots are rejected.
module rob_slot_tracker import rob_pkg::*; #(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned TAG_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [TAG_WIDTH-1:0] set_tag,
  input  logic                 clr_en,
  input  logic [TAG_WIDTH:0]   wr_ptr,
  input  logic [TAG_WIDTH:0]   rd_ptr,
  output logic                 head_done_c,
  output logic                 set_ok_c
);

  logic [DEPTH-1:0]     done_q;
  logic [TAG_WIDTH-1:0] head_c;

  assign head_c      = rd_ptr[TAG_WIDTH-1:0];
  assign head_done_c = done_q[head_c];

`ifdef ROB_CHECK_EN
  logic [TAG_WIDTH:0]   occ_c;
  logic [TAG_WIDTH-1:0] offset_c;

  // A tag is outstanding when its distance from the head is below the occupancy.
  assign occ_c    = wr_ptr - rd_ptr;
  assign offset_c = set_tag - head_c;
  assign set_ok_c = ({1'b0, offset_c} < occ_c) && !done_q[set_tag];
`else
  logic unused_ptr_bits;

  assign unused_ptr_bits = ^{wr_ptr, rd_ptr[TAG_WIDTH]};
  assign set_ok_c        = 1'b1;
`endif

  // Head clear wins so a popped slot never comes back already done.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= '0;
    end else begin
      if (set_en && set_ok_c) begin
        done_q[set_tag] <= 1'b1;
      end
      if (clr_en) begin
        done_q[head_c] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_tagged.sv
// Read-channel reorder buffer: tags ARs with free slots, collects out-of-order tagged
// responses and returns them in AR order with the original ID. Option: ROB_CHECK_EN.
module reorder_buffer_tagged import rob_pkg::*; #(
  parameter  int unsigned DATA_WIDTH = ROB_DATA_WIDTH,
  parameter  int unsigned ID_WIDTH   = ROB_ID_WIDTH,
  parameter  int unsigned DEPTH      = ROB_DEPTH,
  localparam int unsigned TAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [TAG_WIDTH-1:0]  m_arid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [TAG_WIDTH-1:0]  m_rid_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [TAG_WIDTH:0]    occupancy_o,
  output logic                  err_o
);

  logic [TAG_WIDTH:0]    wr_ptr_q;
  logic [TAG_WIDTH:0]    rd_ptr_q;
  logic [ID_WIDTH-1:0]   id_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic                 full_c;
  logic                 empty_c;
  logic                 ar_fire_c;
  logic                 pop_c;
  logic                 head_done_c;
  logic                 rsp_ok_c;
  logic [TAG_WIDTH-1:0] alloc_tag_c;
  logic [TAG_WIDTH-1:0] head_tag_c;

  // Pointer status uses registered pointers only; a pop frees a slot next cycle.
  assign alloc_tag_c = wr_ptr_q[TAG_WIDTH-1:0];
  assign head_tag_c  = rd_ptr_q[TAG_WIDTH-1:0];
  assign full_c      = (alloc_tag_c == head_tag_c) && (wr_ptr_q[TAG_WIDTH] != rd_ptr_q[TAG_WIDTH]);
  assign empty_c     = (wr_ptr_q == rd_ptr_q);
  assign occupancy_o = wr_ptr_q - rd_ptr_q;

  assign m_arvalid_o = s_arvalid_i && !full_c;
  assign s_arready_o = m_arready_i && !full_c;
  assign m_arid_o    = alloc_tag_c;
  assign ar_fire_c   = s_arvalid_i && s_arready_o;

  assign m_rready_o  = 1'b1;

  assign s_rvalid_o  = !empty_c && head_done_c;
  assign s_rdata_o   = data_mem[head_tag_c];
  assign s_rid_o     = id_mem[head_tag_c];
  assign pop_c       = s_rvalid_o && s_rready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (ar_fire_c) begin
        wr_ptr_q <= wr_ptr_q + (TAG_WIDTH+1)'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + (TAG_WIDTH+1)'(1);
      end
    end
  end

  // Slot payload storage; contents are qualified by the pointers and done bits.
  always_ff @(posedge clk) begin
    if (ar_fire_c) begin
      id_mem[alloc_tag_c] <= s_arid_i;
    end
    if (m_rvalid_i && rsp_ok_c) begin
      data_mem[m_rid_i] <= m_rdata_i;
    end
  end

  rob_slot_tracker #(
    .DEPTH     (DEPTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_slot_tracker (
    .clk         (clk),
    .rst         (rst),
    .set_en      (m_rvalid_i),
    .set_tag     (m_rid_i),
    .clr_en      (pop_c),
    .wr_ptr      (wr_ptr_q),
    .rd_ptr      (rd_ptr_q),
    .head_done_c (head_done_c),
    .set_ok_c    (rsp_ok_c)
  );

`ifdef ROB_CHECK_EN
  logic err_q;

  // Sticky until reset: any rejected master response.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (m_rvalid_i && !rsp_ok_c) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_reorder_buffer_tagged.sv
// Bench for reorder_buffer_tagged: vector table, corner-case sequences and a queue-based
// random scoreboard. Error-check cases follow the ROB_CHECK_EN build macro.
module tb_reorder_buffer_tagged;
  import rob_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] s_arid_i;
  logic          s_arvalid_i;
  logic          s_arready_o;
  logic [DW-1:0] s_rdata_o;
  logic [IW-1:0] s_rid_o;
  logic          s_rvalid_o;
  logic          s_rready_i;
  logic [TW-1:0] m_arid_o;
  logic          m_arvalid_o;
  logic          m_arready_i;
  logic [DW-1:0] m_rdata_i;
  logic [TW-1:0] m_rid_i;
  logic          m_rvalid_i;
  logic          m_rready_o;
  logic [TW:0]   occupancy_o;
  logic          err_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reorder_buffer_tagged #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_arid_i(s_arid_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rid_o(s_rid_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .m_arid_o(m_arid_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rid_i(m_rid_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  typedef struct {
    logic          arv;
    logic [IW-1:0] arid;
    logic          mrv;
    logic [TW-1:0] mrid;
    logic [DW-1:0] mdata;
    logic          rrdy;
    logic          e_arrdy;
    logic          e_marv;
    logic [TW-1:0] e_marid;
    logic          e_rv;
    logic [IW-1:0] e_rid;
    logic [DW-1:0] e_rdata;
    logic [TW:0]   e_occ;
  } vec_t;

  typedef struct {
    rob_slot_t slot;
    int        tag;
    bit        done;
  } entry_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_arvalid_i = 1'b0;
    s_arid_i    = '0;
    m_rvalid_i  = 1'b0;
    m_rid_i     = '0;
    m_rdata_i   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vec_t   tbl [18];
    entry_t q[$];
    int     next_tag;
    int     accepted;
    int     cycles;
    int     cand[$];
    int     pick;
    bit     exp_rv;
    bit     exp_full;

    idle();
    s_rready_i  = 1'b1;
    m_arready_i = 1'b1;
    do_reset();

    check("reset_occ", 32'(occupancy_o), 0);
    check("reset_rvalid", 32'(s_rvalid_o), 0);
    check("reset_err", 32'(err_o), 0);
    check("reset_arready", 32'(s_arready_o), 1);
    check("reset_marid", 32'(m_arid_o), 0);
    check("mrready_const", 32'(m_rready_o), 1);

    // arv arid mrv mrid mdata rrdy | arrdy marv marid rv rid rdata occ
    tbl[0]  = '{1, 5, 0, 0, 8'h00, 1, 1, 1, 0, 0, 0, 8'h00, 0};
    tbl[1]  = '{1, 6, 0, 0, 8'h00, 1, 1, 1, 1, 0, 0, 8'h00, 1};
    tbl[2]  = '{1, 7, 0, 0, 8'h00, 1, 1, 1, 2, 0, 0, 8'h00, 2};
    tbl[3]  = '{0, 0, 1, 0, 8'hA0, 1, 1, 0, 3, 0, 0, 8'h00, 3};
    tbl[4]  = '{0, 0, 1, 1, 8'hA1, 1, 1, 0, 3, 1, 5, 8'hA0, 3};
    tbl[5]  = '{0, 0, 1, 2, 8'hA2, 1, 1, 0, 3, 1, 6, 8'hA1, 2};
    tbl[6]  = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 3, 1, 7, 8'hA2, 1};
    tbl[7]  = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 3, 0, 0, 8'h00, 0};
    tbl[8]  = '{1, 1, 0, 0, 8'h00, 1, 1, 1, 3, 0, 0, 8'h00, 0};
    tbl[9]  = '{1, 2, 0, 0, 8'h00, 1, 1, 1, 4, 0, 0, 8'h00, 1};
    tbl[10] = '{1, 3, 0, 0, 8'h00, 1, 1, 1, 5, 0, 0, 8'h00, 2};
    tbl[11] = '{0, 0, 1, 5, 8'hB2, 1, 1, 0, 6, 0, 0, 8'h00, 3};
    tbl[12] = '{0, 0, 1, 4, 8'hB1, 1, 1, 0, 6, 0, 0, 8'h00, 3};
    tbl[13] = '{0, 0, 1, 3, 8'hB0, 1, 1, 0, 6, 0, 0, 8'h00, 3};
    tbl[14] = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 6, 1, 1, 8'hB0, 3};
    tbl[15] = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 6, 1, 2, 8'hB1, 2};
    tbl[16] = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 6, 1, 3, 8'hB2, 1};
    tbl[17] = '{0, 0, 0, 0, 8'h00, 1, 1, 0, 6, 0, 0, 8'h00, 0};

    for (int i = 0; i < 18; i++) begin
      s_arvalid_i = tbl[i].arv;
      s_arid_i    = tbl[i].arid;
      m_rvalid_i  = tbl[i].mrv;
      m_rid_i     = tbl[i].mrid;
      m_rdata_i   = tbl[i].mdata;
      s_rready_i  = tbl[i].rrdy;
      #1;
      check($sformatf("tbl%0d_arready", i), 32'(s_arready_o), 32'(tbl[i].e_arrdy));
      check($sformatf("tbl%0d_marvalid", i), 32'(m_arvalid_o), 32'(tbl[i].e_marv));
      check($sformatf("tbl%0d_marid", i), 32'(m_arid_o), 32'(tbl[i].e_marid));
      check($sformatf("tbl%0d_rvalid", i), 32'(s_rvalid_o), 32'(tbl[i].e_rv));
      check($sformatf("tbl%0d_occ", i), 32'(occupancy_o), 32'(tbl[i].e_occ));
      if (tbl[i].e_rv) begin
        check($sformatf("tbl%0d_rid", i), 32'(s_rid_o), 32'(tbl[i].e_rid));
        check($sformatf("tbl%0d_rdata", i), 32'(s_rdata_o), 32'(tbl[i].e_rdata));
      end
      tick();
    end
    idle();

    // Fill all slots starting from tag 6, then free the head and watch AR reopen.
    for (int i = 0; i < int'(DEPTH); i++) begin
      s_arvalid_i = 1'b1;
      s_arid_i    = IW'(i);
      tick();
    end
    #1;
    check("full_occ", 32'(occupancy_o), DEPTH);
    check("full_arready", 32'(s_arready_o), 0);
    check("full_marvalid", 32'(m_arvalid_o), 0);
    s_arvalid_i = 1'b0;
    m_rvalid_i  = 1'b1;
    m_rid_i     = TW'(6);
    m_rdata_i   = 8'h3C;
    tick();
    m_rvalid_i  = 1'b0;
    check("full_pop_rvalid", 32'(s_rvalid_o), 1);
    check("full_pop_rid", 32'(s_rid_o), 0);
    check("full_pop_rdata", 32'(s_rdata_o), 32'h3C);
    check("full_pop_arready_same_cycle", 32'(s_arready_o), 0);
    tick();
    check("full_after_pop_arready", 32'(s_arready_o), 1);
    check("full_after_pop_occ", 32'(occupancy_o), DEPTH - 1);
    check("full_after_pop_rvalid", 32'(s_rvalid_o), 0);
    do_reset();

    // Slave backpressure with the head done.
    s_arvalid_i = 1'b1;
    s_arid_i    = 4'h9;
    tick();
    s_arvalid_i = 1'b0;
    m_rvalid_i  = 1'b1;
    m_rid_i     = '0;
    m_rdata_i   = 8'h5A;
    s_rready_i  = 1'b0;
    tick();
    m_rvalid_i  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_rvalid", i), 32'(s_rvalid_o), 1);
      check($sformatf("bp%0d_rid", i), 32'(s_rid_o), 9);
      check($sformatf("bp%0d_rdata", i), 32'(s_rdata_o), 32'h5A);
      tick();
    end
    s_rready_i = 1'b1;
    tick();
    check("bp_drained_rvalid", 32'(s_rvalid_o), 0);
    check("bp_drained_occ", 32'(occupancy_o), 0);

    // Mid-operation reset with four outstanding slots, head done.
    for (int i = 1; i <= 4; i++) begin
      s_arvalid_i = 1'b1;
      s_arid_i    = IW'(i);
      tick();
    end
    s_arvalid_i = 1'b0;
    s_rready_i  = 1'b0;
    m_rvalid_i  = 1'b1;
    m_rid_i     = TW'(1);
    m_rdata_i   = 8'h77;
    tick();
    m_rvalid_i  = 1'b0;
    check("mid_pre_rvalid", 32'(s_rvalid_o), 1);
    check("mid_pre_occ", 32'(occupancy_o), 4);
    do_reset();
    check("mid_rst_occ", 32'(occupancy_o), 0);
    check("mid_rst_rvalid", 32'(s_rvalid_o), 0);
    check("mid_rst_marid", 32'(m_arid_o), 0);
    s_rready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_arvalid_i = 1'b1;
      s_arid_i    = IW'(i + 10);
      tick();
    end
    s_arvalid_i = 1'b0;
    m_rvalid_i  = 1'b1;
    m_rid_i     = '0;
    m_rdata_i   = 8'h42;
    tick();
    m_rvalid_i  = 1'b0;
    check("mid_post_rvalid", 32'(s_rvalid_o), 1);
    check("mid_post_rid", 32'(s_rid_o), 10);
    tick();
    check("mid_stale_done_cleared", 32'(s_rvalid_o), 0);

    // Random traffic against an in-order queue scoreboard, several pointer wraps.
    do_reset();
    next_tag = 0;
    accepted = 0;
    cycles   = 0;
    while ((accepted < 3 * int'(DEPTH) || q.size() > 0) && cycles < 4000) begin
      cycles++;
      s_arvalid_i = (accepted < 3 * int'(DEPTH)) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_arid_i    = IW'($urandom);
      m_arready_i = ($urandom_range(0, 3) != 0);
      s_rready_i  = ($urandom_range(0, 3) != 0);
      cand.delete();
      foreach (q[k]) if (!q[k].done) cand.push_back(k);
      pick = -1;
      m_rvalid_i = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick       = cand[$urandom_range(0, cand.size() - 1)];
        m_rvalid_i = 1'b1;
        m_rid_i    = TW'(q[pick].tag);
        m_rdata_i  = DW'($urandom);
      end
      #1;
      exp_full = (q.size() == int'(DEPTH));
      exp_rv   = (q.size() > 0) && q[0].done;
      check("rnd_arready", 32'(s_arready_o), 32'(m_arready_i && !exp_full));
      check("rnd_marvalid", 32'(m_arvalid_o), 32'(s_arvalid_i && !exp_full));
      check("rnd_marid", 32'(m_arid_o), 32'(next_tag));
      check("rnd_occ", 32'(occupancy_o), 32'(q.size()));
      check("rnd_rvalid", 32'(s_rvalid_o), 32'(exp_rv));
      if (exp_rv) begin
        check("rnd_rid", 32'(s_rid_o), 32'(q[0].slot.id));
        check("rnd_rdata", 32'(s_rdata_o), 32'(q[0].slot.data));
      end
      tick();
      if (pick >= 0) begin
        q[pick].done      = 1'b1;
        q[pick].slot.data = m_rdata_i;
      end
      if (exp_rv && s_rready_i) void'(q.pop_front());
      if (s_arvalid_i && m_arready_i && !exp_full) begin
        q.push_back('{slot: '{id: s_arid_i, data: '0}, tag: next_tag, done: 1'b0});
        next_tag = (next_tag + 1) % int'(DEPTH);
        accepted++;
      end
    end
    idle();
    m_arready_i = 1'b1;
    check("rnd_completed_in_budget", 32'(cycles < 4000), 1);
    check("rnd_final_occ", 32'(occupancy_o), 0);
    check("rnd_no_err", 32'(err_o), 0);

`ifdef ROB_CHECK_EN
    // Response to a slot that is not outstanding is flagged and dropped.
    do_reset();
    m_rvalid_i = 1'b1;
    m_rid_i    = '0;
    m_rdata_i  = 8'hEE;
    tick();
    m_rvalid_i = 1'b0;
    check("chk_err_set", 32'(err_o), 1);
    s_arvalid_i = 1'b1;
    s_arid_i    = 4'h4;
    tick();
    s_arvalid_i = 1'b0;
    check("chk_dropped_rvalid", 32'(s_rvalid_o), 0);
    check("chk_err_sticky", 32'(err_o), 1);
    m_rvalid_i = 1'b1;
    m_rid_i    = '0;
    m_rdata_i  = 8'h11;
    tick();
    m_rvalid_i = 1'b0;
    check("chk_good_rvalid", 32'(s_rvalid_o), 1);
    check("chk_good_rdata", 32'(s_rdata_o), 32'h11);
    check("chk_good_rid", 32'(s_rid_o), 4);
    check("chk_err_still", 32'(err_o), 1);
    tick();
    do_reset();
    check("chk_err_cleared", 32'(err_o), 0);
`else
    // Without the check, a stray response raises no error.
    do_reset();
    m_rvalid_i = 1'b1;
    m_rid_i    = TW'(3);
    m_rdata_i  = 8'hEE;
    tick();
    m_rvalid_i = 1'b0;
    check("nochk_err_zero", 32'(err_o), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
